codec_word_packer: RTL and testbench

CODEC_WORD_PACKER -- requirements
Module: codec_word_packer

---
 rtl/codec_word_packer_if.sv | 25 ++
 rtl/codec_word_packer.sv | 95 +++++++++
 tb/tb_codec_word_packer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/codec_word_packer_if.sv
// Bitstream-word input and 128-bit FIFO output bundle for codec_word_packer.
// master = upstream/downstream environment side, slave = packer side.
interface codec_word_packer_if #(
   parameter int LVL_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic             codec_data_rd_en;
   logic [127:0]     codec_data;
   logic             codec_data_valid;
   logic [LVL_W-1:0] fifo_level;
   logic             underflow;

   modport master (
      output in_valid, in_data, in_last, codec_data_rd_en,
      input  in_ready, codec_data, codec_data_valid, fifo_level, underflow
   );

   modport slave (
      input  in_valid, in_data, in_last, codec_data_rd_en,
      output in_ready, codec_data, codec_data_valid, fifo_level, underflow
   );
endinterface

// File: rtl/codec_word_packer.sv
// Packs 32-bit bitstream words MSB-first into 128-bit entries and queues them in a
// first-word-fall-through FIFO for the downstream bit parser.
module codec_word_packer #(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   codec_word_packer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [1:0]       wcnt_q, wcnt_d;
   logic [127:0]     asm_q, asm_d, wr_word;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             rdy_q, rdy_d;
   logic             uf_q, uf_d;
   logic             push, done, pop, not_empty;
   logic [127:0]     mem [DEPTH];

   function automatic logic [127:0] lane_insert(input logic [127:0] acc,
                                                input logic [1:0]   lane,
                                                input logic [31:0]  w);
      logic [127:0] r;
      r = acc;
      case (lane)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

   always_comb begin
      not_empty = (lvl_q != '0);
      push      = bus.in_valid & rdy_q;
      done      = push & ((wcnt_q == 2'd3) | bus.in_last);
      pop       = bus.codec_data_rd_en & not_empty;
      wr_word   = lane_insert(asm_q, wcnt_q, bus.in_data);

      wcnt_d   = wcnt_q;
      asm_d    = asm_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         if (done) begin
            wcnt_d   = 2'd0;
            asm_d    = '0;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wcnt_d = wcnt_q + 2'd1;
            asm_d  = wr_word;
         end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      // in_ready is registered from the next level so a same-cycle pop cannot reopen it.
      lvl_d = lvl_q + {{(LVL_W-1){1'b0}}, done} - {{(LVL_W-1){1'b0}}, pop};
      rdy_d = (lvl_d != LVL_W'(DEPTH));
      uf_d  = uf_q | (bus.codec_data_rd_en & ~not_empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q   <= 2'd0;
         asm_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lvl_q    <= '0;
         rdy_q    <= 1'b0;
         uf_q     <= 1'b0;
      end else begin
         wcnt_q   <= wcnt_d;
         asm_q    <= asm_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         lvl_q    <= lvl_d;
         rdy_q    <= rdy_d;
         uf_q     <= uf_d;
      end
   end

   // Storage holds data only; validity comes from the level, so it needs no reset.
   always_ff @(posedge clk) begin
      if (done) mem[wr_ptr_q] <= wr_word;
   end

   assign bus.in_ready         = rdy_q;
   assign bus.codec_data_valid = not_empty;
   assign bus.codec_data       = not_empty ? mem[rd_ptr_q] : '0;
   assign bus.fifo_level       = lvl_q;
   assign bus.underflow        = uf_q;
endmodule

// File: tb/tb_codec_word_packer.sv
// Bench for codec_word_packer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_codec_word_packer;
   localparam int DEPTH = 4;
   localparam int LVL_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   codec_word_packer_if #(.LVL_W(LVL_W)) bus ();

   codec_word_packer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: queue of completed 128-bit entries plus the word being assembled.
   logic [127:0] m_q[$];
   logic [127:0] m_part;
   int           m_cnt;
   logic         m_uf;
   logic         m_ren;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_part = '0;
         m_cnt  = 0;
         m_uf   = 1'b0;
         m_ren  = 1'b0;
      end else begin
         logic hs;
         hs = bus.in_valid && m_ren && (m_q.size() != DEPTH);
         if (bus.codec_data_rd_en) begin
            if (m_q.size() == 0) m_uf = 1'b1;
            else void'(m_q.pop_front());
         end
         if (hs) begin
            m_part[127 - 32*m_cnt -: 32] = bus.in_data;
            if (m_cnt == 3 || bus.in_last) begin
               m_q.push_back(m_part);
               m_part = '0;
               m_cnt  = 0;
            end else begin
               m_cnt++;
            end
         end
         m_ren = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model.in_ready", 128'(bus.in_ready), 128'(m_ren && (m_q.size() != DEPTH)));
      chk("model.valid", 128'(bus.codec_data_valid), 128'(m_q.size() != 0));
      chk("model.data", bus.codec_data, (m_q.size() != 0) ? m_q[0] : 128'd0);
      chk("model.level", 128'(bus.fifo_level), 128'(m_q.size()));
      chk("model.underflow", 128'(bus.underflow), 128'(m_uf));
   end

   task automatic step(input logic v, input logic [31:0] d, input logic l, input logic rd);
      bus.in_valid         = v;
      bus.in_data          = d;
      bus.in_last          = l;
      bus.codec_data_rd_en = rd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".in_ready"}, 128'(bus.in_ready), 128'd0);
      chk({tag, ".valid"}, 128'(bus.codec_data_valid), 128'd0);
      chk({tag, ".data"}, bus.codec_data, 128'd0);
      chk({tag, ".level"}, 128'(bus.fifo_level), 128'd0);
      chk({tag, ".underflow"}, 128'(bus.underflow), 128'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.codec_data_rd_en = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk("rst.ready_after", 128'(bus.in_ready), 128'd1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.codec_data_rd_en = 1'b0;
      do_reset();

      // Full four-word entry.
      step(1'b1, 32'h11111111, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 1'b0, 1'b0);
      step(1'b1, 32'h33333333, 1'b0, 1'b0);
      step(1'b1, 32'h44444444, 1'b0, 1'b0);
      chk("four.data", bus.codec_data, 128'h11111111222222223333333344444444);
      chk("four.valid", 128'(bus.codec_data_valid), 128'd1);
      chk("four.level", 128'(bus.fifo_level), 128'd1);
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("four.pop_level", 128'(bus.fifo_level), 128'd0);

      // Short slice closed by in_last, then a fresh word starts at the top lane.
      step(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
      step(1'b1, 32'hBBBBBBBB, 1'b1, 1'b0);
      chk("last.data", bus.codec_data, 128'hAAAAAAAABBBBBBBB0000000000000000);
      step(1'b1, 32'hCCCCCCCC, 1'b1, 1'b1);
      chk("last.next_data", bus.codec_data, 128'hCCCCCCCC000000000000000000000000);
      chk("last.level", 128'(bus.fifo_level), 128'd1);
      step(1'b0, 32'd0, 1'b0, 1'b1);

      // Fill to full, then valid+pop at full pops only.
      for (int i = 0; i < 16; i++) step(1'b1, 32'h10000000 + i, 1'b0, 1'b0);
      chk("full.level", 128'(bus.fifo_level), 128'd4);
      chk("full.in_ready", 128'(bus.in_ready), 128'd0);
      step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
      chk("full.pop_level", 128'(bus.fifo_level), 128'd3);
      chk("full.pop_ready", 128'(bus.in_ready), 128'd1);
      chk("full.pop_head", bus.codec_data, 128'h10000004100000051000000610000007);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1);

      // Underflow is sticky until reset.
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("uf.set", 128'(bus.underflow), 128'd1);
      chk("uf.level", 128'(bus.fifo_level), 128'd0);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk("uf.sticky", 128'(bus.underflow), 128'd1);
      do_reset();

      // Reset mid-burst: two queued entries and a half-built word.
      for (int i = 0; i < 10; i++) step(1'b1, 32'h50000000 + i, 1'b0, 1'b0);
      chk("mid.level_before", 128'(bus.fifo_level), 128'd2);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      step(1'b1, 32'h01234567, 1'b0, 1'b0);
      step(1'b1, 32'h89ABCDEF, 1'b0, 1'b0);
      step(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0);
      chk("mid.fresh_data", bus.codec_data, 128'hDEADBEEF0123456789ABCDEF0F0F0F0F);
      chk("mid.fresh_level", 128'(bus.fifo_level), 128'd1);
      step(1'b0, 32'd0, 1'b0, 1'b1);

      // Steady stream with pops held high: 64 entries, pointers wrap many times.
      for (int i = 0; i < 256; i++) step(1'b1, 32'hA0000000 + i, 1'b0, 1'b1);
      step(1'b0, 32'd0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(1)), $urandom, ($urandom_range(3) == 0),
              ($urandom_range(2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
